// File: rtl/ld_cell_pkg.sv
// Shared types and constants for the load-cell conversion scheduler.
// Holds the FSM state encoding, A2D channels, timer terminal counts, thresholds.
package ld_cell_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_L = 3'd1,
        WAIT_R = 3'd2,
        WAIT_B = 3'd3,
        CALC   = 3'd4
    } state_t;

    localparam logic [2:0] CH_LFT_DEF  = 3'd0;
    localparam logic [2:0] CH_RGHT_DEF = 3'd4;
    localparam logic [2:0] CH_BATT_DEF = 3'd5;

    localparam logic [25:0] TMR_FULL_CNT     = 26'd65_000_000;
    localparam logic [25:0] TMR_FULL_CNT_SIM = 26'h000_FFFF;

    localparam logic [11:0] MIN_RIDER_WT_DEF = 12'h200;
    localparam logic [11:0] HYST_DEF         = 12'h040;

    function automatic logic [12:0] thr_hi(input logic [11:0] m,
                                           input logic [11:0] h);
        return {1'b0, m} + {1'b0, h};
    endfunction

    // Lower threshold floors at zero rather than wrapping.
    function automatic logic [12:0] thr_lo(input logic [11:0] m,
                                           input logic [11:0] h);
        return (m > h) ? {1'b0, m - h} : 13'd0;
    endfunction

    localparam logic [12:0] SUM_HI_DEF = thr_hi(MIN_RIDER_WT_DEF, HYST_DEF);
    localparam logic [12:0] SUM_LO_DEF = thr_lo(MIN_RIDER_WT_DEF, HYST_DEF);

endpackage

// File: rtl/ld_cell_sched_if.sv
// Conversion request/response bundle between the scheduler and the A2D block.
// master = scheduler, slave = A2D/SPI interface.
interface ld_cell_sched_if;
    logic        cnv_req;
    logic [2:0]  cnv_chnl;
    logic        cnv_done;
    logic [11:0] cnv_data;

    modport master (
        output cnv_req,
        output cnv_chnl,
        input  cnv_done,
        input  cnv_data
    );

    modport slave (
        input  cnv_req,
        input  cnv_chnl,
        output cnv_done,
        output cnv_data
    );
endinterface

// File: rtl/settle_tmr.sv
// Rider-settle timer: saturating up-counter with synchronous clear.
// FAST_SIM shortens the terminal count for simulation.
module settle_tmr
    import ld_cell_pkg::*;
#(
    parameter bit FAST_SIM = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tmr_full
);

    localparam logic [25:0] TERM = FAST_SIM ? TMR_FULL_CNT_SIM : TMR_FULL_CNT;

    logic [25:0] cnt_q, cnt_d;
    logic        full_q, full_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = 26'd0;
        else if (cnt_q != TERM)
            cnt_d = cnt_q + 26'd1;
        full_d = (cnt_q == TERM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 26'd0;
            full_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign tmr_full = full_q;

endmodule

// File: rtl/ld_cell_sched.sv
// Round-robin left/right/battery A2D sequencer with rider threshold flags.
// Define A2D_TIMEOUT_EN to add the conversion watchdog and sticky a2d_err.
module ld_cell_sched
    import ld_cell_pkg::*;
#(
    parameter logic [11:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
    parameter logic [11:0] HYST         = HYST_DEF,
    parameter bit          FAST_SIM     = 1'b0,
    parameter logic [2:0]  CH_LFT       = CH_LFT_DEF,
    parameter logic [2:0]  CH_RGHT      = CH_RGHT_DEF,
    parameter logic [2:0]  CH_BATT      = CH_BATT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   nxt,
    ld_cell_sched_if.master        a2d,
    input  logic                   clr_tmr,
    output logic [11:0]            lft_ld,
    output logic [11:0]            rght_ld,
    output logic [11:0]            batt,
    output logic                   vld,
    output logic                   sum_gt_min,
    output logic                   sum_lt_min,
    output logic                   diff_gt_1_4,
    output logic                   diff_gt_15_16,
`ifdef A2D_TIMEOUT_EN
    output logic                   a2d_err,
`endif
    output logic                   tmr_full
);

    localparam logic [12:0] SUM_HI = thr_hi(MIN_RIDER_WT, HYST);
    localparam logic [12:0] SUM_LO = thr_lo(MIN_RIDER_WT, HYST);

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [2:0]  chnl_q, chnl_d;
    logic [11:0] lft_q, lft_d, rght_q, rght_d, batt_q, batt_d;
    logic        vld_q, vld_d;
    logic        gt_q, gt_d, lt_q, lt_d;
    logic        d14_q, d14_d, d1516_q, d1516_d;
    logic [12:0] sum;
    logic [11:0] diff;
    logic        waiting;
    logic        tmo;

    assign waiting = (state_q == WAIT_L) || (state_q == WAIT_R) ||
                     (state_q == WAIT_B);

`ifdef A2D_TIMEOUT_EN
    logic [11:0] wdog_q, wdog_d;
    logic        err_q, err_d;

    always_comb begin
        wdog_d = wdog_q;
        if (req_q)
            wdog_d = 12'd1;
        else if (waiting)
            wdog_d = wdog_q + 12'd1;
    end

    assign tmo   = waiting && !a2d.cnv_done && (wdog_q == 12'hFFF);
    assign err_d = err_q | tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= 12'd0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign a2d_err = err_q;
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (nxt) state_d = WAIT_L;
            WAIT_L:  if (a2d.cnv_done) state_d = WAIT_R;
            WAIT_R:  if (a2d.cnv_done) state_d = WAIT_B;
            WAIT_B:  if (a2d.cnv_done) state_d = CALC;
            CALC:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (tmo)
            state_d = IDLE;
    end

    assign sum  = {1'b0, lft_q} + {1'b0, rght_q};
    assign diff = (lft_q >= rght_q) ? lft_q - rght_q : rght_q - lft_q;

    // Flags register on the final done so they land together with vld.
    always_comb begin
        req_d   = 1'b0;
        chnl_d  = chnl_q;
        lft_d   = lft_q;
        rght_d  = rght_q;
        batt_d  = batt_q;
        vld_d   = 1'b0;
        gt_d    = gt_q;
        lt_d    = lt_q;
        d14_d   = d14_q;
        d1516_d = d1516_q;
        unique case (state_q)
            IDLE: begin
                if (nxt) begin
                    req_d  = 1'b1;
                    chnl_d = CH_LFT;
                end
            end
            WAIT_L: begin
                if (a2d.cnv_done) begin
                    lft_d  = a2d.cnv_data;
                    req_d  = 1'b1;
                    chnl_d = CH_RGHT;
                end
            end
            WAIT_R: begin
                if (a2d.cnv_done) begin
                    rght_d = a2d.cnv_data;
                    req_d  = 1'b1;
                    chnl_d = CH_BATT;
                end
            end
            WAIT_B: begin
                if (a2d.cnv_done) begin
                    batt_d  = a2d.cnv_data;
                    vld_d   = 1'b1;
                    gt_d    = sum > SUM_HI;
                    lt_d    = sum < SUM_LO;
                    d14_d   = {1'b0, diff} > (sum >> 2);
                    d1516_d = {1'b0, diff} > (sum - (sum >> 4));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            chnl_q  <= CH_LFT;
            lft_q   <= 12'd0;
            rght_q  <= 12'd0;
            batt_q  <= 12'd0;
            vld_q   <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b1;
            d14_q   <= 1'b0;
            d1516_q <= 1'b0;
        end else begin
            req_q   <= req_d;
            chnl_q  <= chnl_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
            batt_q  <= batt_d;
            vld_q   <= vld_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            d14_q   <= d14_d;
            d1516_q <= d1516_d;
        end
    end

    assign a2d.cnv_req    = req_q;
    assign a2d.cnv_chnl   = chnl_q;
    assign lft_ld         = lft_q;
    assign rght_ld        = rght_q;
    assign batt           = batt_q;
    assign vld            = vld_q;
    assign sum_gt_min     = gt_q;
    assign sum_lt_min     = lt_q;
    assign diff_gt_1_4    = d14_q;
    assign diff_gt_15_16  = d1516_q;

    settle_tmr #(.FAST_SIM(FAST_SIM)) u_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_tmr),
        .tmr_full (tmr_full)
    );

endmodule
